clk_en_gen: RTL

CLK_EN_GEN -- requirements
Module: clk_en_gen

---
 rtl/clk_en_gen.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/clk_en_gen.sv
// clk_en_gen: NCH clock-enable channels with programmable divide/phase and a realignment FSM.
// Define CLK_EN_GEN_DUTY_EN to add the clk_div_out divided square-wave outputs.
module clk_en_gen #(
  parameter int NCH     = 4,
  parameter int DIVW    = 8,
  parameter int DEF_DIV = 8,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clkin,
  input  logic            rst_n,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [DIVW-1:0] cfg_div,
  input  logic [DIVW-1:0] cfg_phase,
  input  logic            sync,
  output logic [NCH-1:0]  en_out,
  output logic            locked
`ifdef CLK_EN_GEN_DUTY_EN
  ,
  output logic [NCH-1:0]  clk_div_out
`endif
);

  localparam logic [1:0]      IDLE   = 2'd0;
  localparam logic [1:0]      LOAD   = 2'd1;
  localparam logic [1:0]      ALIGN  = 2'd2;
  localparam logic [1:0]      SETTLE = 2'd3;
  localparam logic [DIVW-1:0] ONE    = DIVW'(1);
  localparam logic [CHW:0]    NCH_W  = (CHW+1)'(NCH);

  logic [1:0]      state_q, state_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [DIVW-1:0] cdiv_q, cdiv_d, cphase_q, cphase_d;
  logic [DIVW-1:0] div_q [NCH];
  logic [DIVW-1:0] div_d [NCH];
  logic [DIVW-1:0] phase_q [NCH];
  logic [DIVW-1:0] phase_d [NCH];
  logic [DIVW-1:0] cnt_q [NCH];
  logic [DIVW-1:0] cnt_d [NCH];
  logic [DIVW-1:0] deff_s [NCH];
  logic [DIVW-1:0] eph_s [NCH];
  logic [NCH-1:0]  last_s, en_out_q, en_out_d;
  logic            locked_q, locked_d, cfg_ready_q, cfg_ready_d;
  logic            clr_s, wrap_sel_s;

  // Effective divide (0/1 act as 1), clamped phase and last-count detect per channel.
  always_comb begin
    last_s = '0;
    for (int i = 0; i < NCH; i++) begin
      deff_s[i] = (div_q[i] <= ONE) ? ONE : div_q[i];
      eph_s[i]  = (phase_q[i] < deff_s[i]) ? phase_q[i] : deff_s[i] - ONE;
      last_s[i] = (cnt_q[i] >= deff_s[i] - ONE);
    end
  end

  // Counter advance, realignment clear and enable decode.
  always_comb begin
    clr_s    = (state_q == ALIGN) || ((state_q == IDLE) && sync && !cfg_valid);
    en_out_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (clr_s || last_s[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end
      en_out_d[i] = (cnt_q[i] == eph_s[i]);
    end
  end

  // Control FSM: accept a request, write it, realign, then wait for the captured channel to wrap.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    cdiv_d     = cdiv_q;
    cphase_d   = cphase_q;
    locked_d   = locked_q;
    div_d      = div_q;
    phase_d    = phase_q;
    wrap_sel_s = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == i[CHW-1:0]) begin
        wrap_sel_s = last_s[i];
      end else begin
        wrap_sel_s = wrap_sel_s;
      end
    end
    case (state_q)
      IDLE: begin
        // Out-of-range channels complete the handshake but are dropped here.
        if (cfg_valid && ({1'b0, cfg_ch} < NCH_W)) begin
          state_d  = LOAD;
          ch_d     = cfg_ch;
          cdiv_d   = cfg_div;
          cphase_d = cfg_phase;
        end else begin
          state_d  = IDLE;
        end
      end
      LOAD: begin
        for (int i = 0; i < NCH; i++) begin
          if (ch_q == i[CHW-1:0]) begin
            div_d[i]   = cdiv_q;
            phase_d[i] = cphase_q;
          end else begin
            div_d[i]   = div_q[i];
            phase_d[i] = phase_q[i];
          end
        end
        locked_d = 1'b0;
        state_d  = ALIGN;
      end
      ALIGN: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        if (wrap_sel_s) begin
          locked_d = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d  = SETTLE;
        end
      end
      default: begin
        state_d = ALIGN;
      end
    endcase
    cfg_ready_d = (state_d == IDLE);
  end

  // State, configuration and output registers.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ALIGN;
      ch_q        <= '0;
      cdiv_q      <= '0;
      cphase_q    <= '0;
      en_out_q    <= '0;
      locked_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        div_q[i]   <= DIVW'(DEF_DIV);
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cdiv_q      <= cdiv_d;
      cphase_q    <= cphase_d;
      en_out_q    <= en_out_d;
      locked_q    <= locked_d;
      cfg_ready_q <= cfg_ready_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
    end
  end

  assign en_out    = en_out_q;
  assign locked    = locked_q;
  assign cfg_ready = cfg_ready_q;

`ifdef CLK_EN_GEN_DUTY_EN
  logic [NCH-1:0] clk_div_q, clk_div_d;

  // Square wave high for the first floor(div/2) counts of each period; off when div <= 1.
  always_comb begin
    clk_div_d = '0;
    for (int i = 0; i < NCH; i++) begin
      clk_div_d[i] = (div_q[i] > ONE) && (cnt_q[i] < (div_q[i] >> 1));
    end
  end

  // Divided clock register.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      clk_div_q <= '0;
    end else begin
      clk_div_q <= clk_div_d;
    end
  end

  assign clk_div_out = clk_div_q;
`endif

endmodule
